// File: rtl/cpu_pkg.sv
// Shared encodings for the MEM-stage store path: store opcodes, store FSM
// states and the alignment rule used to reject a store before any memory access.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_W   = 2'b00,
    ST_H   = 2'b01,
    ST_B   = 2'b10,
    ST_RSV = 2'b11
  } store_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  // A byte store can never be misaligned; the reserved opcode is always rejected.
  function automatic logic store_misaligned(input logic [1:0] op, input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (op)
      ST_W:    bad = (lane != 2'b00);
      ST_H:    bad = lane[0];
      ST_B:    bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops a byte or halfword into the addressed lane of
// an existing memory word, leaving all other bytes untouched.
module store_lane_merge
  import cpu_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [31:0] old_word,
  input  logic [15:0] wd,
  input  logic [1:0]  op,
  input  logic [1:0]  lane_addr,
  output logic [31:0] merged
);

  logic [1:0] bsel;
  logic       hsel;

  // Big-endian numbering mirrors the lane: byte k lives in physical slot 3-k.
  always_comb begin
    bsel   = (BIG_ENDIAN != 0) ? ~lane_addr : lane_addr;
    hsel   = (BIG_ENDIAN != 0) ? ~lane_addr[1] : lane_addr[1];
    merged = old_word;
    case (op)
      ST_B: merged[{bsel, 3'b000} +: 8] = wd[7:0];
      ST_H: begin
        if (hsel) merged[31:16] = wd;
        else      merged[15:0]  = wd;
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only data memory: sw writes directly, sb/sh run as
// read-modify-write. All outputs come from registers.
module store_rmw_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rd_valid,
  output logic              mem_wr_req,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wr_ack
);

  state_e            state, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wd_q, wd_d;
  logic [31:0]       wdata_d;
  logic [31:0]       merged;

  store_lane_merge #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_merge (
    .old_word (mem_rdata),
    .wd       (wd_q),
    .op       (op_q),
    .lane_addr(addr_q[1:0]),
    .merged   (merged)
  );

  // mem_addr is a pure rewiring of the latched address register.
  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d = state;
    op_d    = op_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    wdata_d = mem_wdata;
    case (state)
      IDLE: begin
        if (start) begin
          op_d   = store_op;
          addr_d = addr;
          wd_d   = wdata[15:0];
          if (store_misaligned(store_op, addr[1:0])) begin
            state_d = ERR;
          end else if (store_op == ST_W) begin
            state_d = WR;
            wdata_d = wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (mem_rd_valid) begin
          wdata_d = merged;
          state_d = WR;
        end
      end
      // A read-valid arriving together with the ack is ignored here.
      WR: begin
        if (mem_wr_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each pulse lines up with
  // the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= 2'b00;
      addr_q     <= '0;
      wd_q       <= 16'h0000;
      mem_wdata  <= 32'h0000_0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_err   <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      mem_wdata  <= wdata_d;
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE) || (state_d == ERR);
      addr_err   <= (state_d == ERR);
      mem_rd_req <= (state_d == RD);
      mem_wr_req <= (state_d == WR);
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed cases plus randomized stores against a
// word-memory model with random latencies and stray handshakes.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  store_op;
  logic [31:0] addr, wdata;
  logic        busy, done, addr_err;
  logic [31:0] mem_addr;
  logic        mem_rd_req, mem_rd_valid, mem_wr_req, mem_wr_ack;
  logic [31:0] mem_rdata, mem_wdata;

  store_rmw_unit #(.ADDR_W(32), .BIG_ENDIAN(0)) dut (
    .clk(clk), .reset(reset), .start(start), .store_op(store_op), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .addr_err(addr_err),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_rdata(mem_rdata),
    .mem_rd_valid(mem_rd_valid), .mem_wr_req(mem_wr_req), .mem_wdata(mem_wdata),
    .mem_wr_ack(mem_wr_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference memory and the expectation of the store in flight.
  logic [31:0] mem_model [int];
  logic [31:0] exp_addr, exp_wdata, cur_rdata;
  logic        exp_rmw = 1'b0, exp_wr = 1'b0, exp_err = 1'b0;
  int          rd_lat = 1, wr_lat = 1;
  bit          stray_en = 1'b0, mon_en = 1'b0;
  bit          seen_rd, seen_wr;
  logic [31:0] seen_wdata;
  int          done_cnt = 0;

  function automatic logic [31:0] model_merge(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] old, input logic [31:0] wd);
    int sh;
    case (op)
      2'd0: return wd;
      2'd1: begin
        sh = a[1] ? 16 : 0;
        return (old & ~(32'h0000FFFF << sh)) | ((wd & 32'h0000FFFF) << sh);
      end
      2'd2: begin
        sh = 8 * int'(a[1:0]);
        return (old & ~(32'h000000FF << sh)) | ((wd & 32'h000000FF) << sh);
      end
      default: return old;
    endcase
  endfunction

  function automatic logic model_err(input logic [1:0] op, input logic [31:0] a);
    return (op == 2'd3) || (op == 2'd1 && a[0]) || (op == 2'd0 && a[1:0] != 2'b00);
  endfunction

  // Memory responder: answers a held request after rd_lat / wr_lat cycles.
  initial begin
    int rw, ww;
    rw = 0; ww = 0;
    mem_rd_valid = 1'b0; mem_wr_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_rd_valid = 1'b0;
      mem_wr_ack   = 1'b0;
      if (reset) begin
        rw = 0; ww = 0;
      end else begin
        if (mem_rd_req) begin
          if (rw >= rd_lat) begin mem_rd_valid = 1'b1; mem_rdata = cur_rdata; rw = 0; end
          else rw++;
        end else begin
          rw = 0;
          if (stray_en && $urandom_range(0, 3) == 0) begin
            mem_rd_valid = 1'b1; mem_rdata = $urandom;
          end
        end
        if (mem_wr_req) begin
          if (ww >= wr_lat) begin mem_wr_ack = 1'b1; ww = 0; end
          else ww++;
        end else begin
          ww = 0;
          if (stray_en && $urandom_range(0, 3) == 0) mem_wr_ack = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the expectation of the current store.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (mem_rd_req) begin
          seen_rd = 1'b1;
          chk1("rd_req_legal", mem_rd_req, exp_rmw);
          check("rd_addr", mem_addr, exp_addr);
        end
        if (mem_wr_req) begin
          seen_wr = 1'b1;
          seen_wdata = mem_wdata;
          chk1("wr_req_legal", mem_wr_req, exp_wr);
          check("wr_addr", mem_addr, exp_addr);
          check("wr_data", mem_wdata, exp_wdata);
        end
        if (done) begin
          done_cnt++;
          chk1("addr_err", addr_err, exp_err);
        end
        if (addr_err) chk1("err_needs_done", done, 1'b1);
      end
    end
  end

  task automatic set_expect(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (!mem_model.exists(int'(wa))) mem_model[int'(wa)] = $urandom;
    cur_rdata = mem_model[int'(wa)];
    exp_err   = model_err(op, a);
    exp_addr  = wa;
    exp_rmw   = !exp_err && (op != 2'd0);
    exp_wr    = !exp_err;
    exp_wdata = model_merge(op, a, cur_rdata, wd);
    seen_rd   = 1'b0;
    seen_wr   = 1'b0;
  endtask

  task automatic do_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input bit mid_start, output logic [31:0] got_wdata, output int lat);
    int  exp_lat, d0;
    bit  got;
    set_expect(op, a, wd);
    exp_lat = exp_err ? 1 : ((op == 2'd0) ? 2 + wr_lat : 3 + rd_lat + wr_lat);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; store_op = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; store_op = 2'($urandom); addr = $urandom; wdata = $urandom;
    lat = 0; got = 1'b0;
    for (int n = 1; n <= 80 && !got; n++) begin
      @(negedge clk);
      if (n == 1) chk1("busy_after_start", busy, 1'b1);
      if (mid_start && n == 2) begin start = 1'b1; store_op = 2'd0; addr = exp_addr + 32'd4; end
      if (mid_start && n == 3) start = 1'b0;
      if (done) begin got = 1'b1; lat = n; end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    else      check("latency", lat, exp_lat);
    @(negedge clk);
    chk1("done_single_pulse", done, 1'b0);
    chk1("idle_not_busy", busy, 1'b0);
    check("done_count", done_cnt - d0, 32'd1);
    if (!exp_err) mem_model[int'(exp_addr)] = exp_wdata;
    got_wdata = seen_wdata;
    exp_rmw = 1'b0;
    exp_wr  = 1'b0;
  endtask

  initial begin
    logic [31:0] gw;
    int          lat;
    logic [1:0]  op;
    logic [31:0] a;
    bit          ms;

    reset = 1'b1; start = 1'b0; store_op = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_rd_req", mem_rd_req, 1'b0);
    chk1("rst_wr_req", mem_wr_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    check("model_sb", model_merge(2'd2, 32'h203, 32'h11223344, 32'h000000AB), 32'hAB223344);
    check("model_sh", model_merge(2'd1, 32'h302, 32'h11223344, 32'hFFFF5A5A), 32'h5A5A3344);

    rd_lat = 1; wr_lat = 1;
    do_store(2'd0, 32'h100, 32'hDEADBEEF, 1'b0, gw, lat);
    check("sw_wdata", gw, 32'hDEADBEEF);
    check("sw_latency", lat, 32'd3);
    chk1("sw_no_read", seen_rd, 1'b0);

    mem_model[32'h200] = 32'h11223344;
    do_store(2'd2, 32'h203, 32'h000000AB, 1'b0, gw, lat);
    check("sb_wdata", gw, 32'hAB223344);
    check("sb_latency", lat, 32'd5);

    mem_model[32'h300] = 32'h11223344;
    do_store(2'd1, 32'h302, 32'hFFFF5A5A, 1'b0, gw, lat);
    check("sh_wdata", gw, 32'h5A5A3344);
    check("sh_latency", lat, 32'd5);

    do_store(2'd1, 32'h001, 32'h1234, 1'b0, gw, lat);
    check("sh_mis_latency", lat, 32'd1);
    chk1("sh_mis_no_rd", seen_rd, 1'b0);
    chk1("sh_mis_no_wr", seen_wr, 1'b0);
    do_store(2'd0, 32'h002, 32'h1234, 1'b0, gw, lat);
    check("sw_mis_latency", lat, 32'd1);
    chk1("sw_mis_no_wr", seen_wr, 1'b0);
    do_store(2'd3, 32'h000, 32'h1234, 1'b0, gw, lat);
    check("rsv_latency", lat, 32'd1);
    chk1("rsv_no_rd", seen_rd, 1'b0);
    chk1("rsv_no_wr", seen_wr, 1'b0);

    // Back-pressure: read-valid held off 4 cycles, write-ack 3, plus a stray start.
    rd_lat = 4; wr_lat = 3;
    do_store(2'd2, 32'h203, 32'h00000077, 1'b1, gw, lat);
    check("bp_wdata", gw, 32'h77223344);
    check("bp_latency", lat, 32'd10);

    // Reset while a write is pending.
    rd_lat = 1; wr_lat = 8;
    set_expect(2'd2, 32'h501, 32'h000000CD);
    @(posedge clk); #1;
    start = 1'b1; store_op = 2'd2; addr = 32'h501; wdata = 32'h000000CD;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20 && !mem_wr_req; n++) @(negedge clk);
    chk1("rst_test_in_wr", mem_wr_req, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rst_wr_busy", busy, 1'b0);
    chk1("rst_wr_done", done, 1'b0);
    chk1("rst_wr_err", addr_err, 1'b0);
    chk1("rst_wr_wr_req", mem_wr_req, 1'b0);
    chk1("rst_wr_rd_req", mem_rd_req, 1'b0);
    check("rst_wr_addr", mem_addr, 32'h0);
    check("rst_wr_wdata", mem_wdata, 32'h0);
    exp_rmw = 1'b0; exp_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr_lat = 1;
    do_store(2'd0, 32'h600, 32'h12345678, 1'b0, gw, lat);
    check("post_rst_sw_wdata", gw, 32'h12345678);
    check("post_rst_sw_latency", lat, 32'd3);

    // Randomized stores with stray handshakes and varying memory latency.
    stray_en = 1'b1;
    repeat (300) begin
      op     = 2'($urandom_range(0, 3));
      a      = 32'h400 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      rd_lat = $urandom_range(1, 4);
      wr_lat = $urandom_range(1, 4);
      ms     = (op == 2'd1 || op == 2'd2) && ($urandom_range(0, 1) == 1);
      do_store(op, a, $urandom, ms, gw, lat);
    end
    stray_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
